gba_mem_ctrl: RTL and testbench
===============================

// Module: gba_mem_ctrl
// PURPOSE
//  Memory controller downstream of the ARMv4T core's single memory port (mem_addr/mem_data/mem_width/mem_read/mem_write/mem_ok).
//  Decodes the GBA address map into regions, inserts per-region wait states and aligns byte/halfword lanes.
//  Runs a req/ack handshake to the region devices (BIOS, EWRAM, IWRAM, IO, palette, VRAM, OAM, ROM).
//  Returns read data with a one-cycle mem_ok strobe.
// PARAMETERS
//  WS_BIOS   0    extra wait cycles after dev_ack, region 0x0
//  WS_EWRAM  2    same, region 0x2
//  WS_IWRAM  0    same, regions 0x3..0x7 (IWRAM/IO/PAL/VRAM/OAM share this value)
//  WS_ROM    4    same, regions 0x8..0xD (ROM)
//  TIMEOUT   255  max cycles waiting for dev_ack before abort (8-bit counter)
// PORTS
//  clk        in     1   clock
//  rstn       in     1   synchronous active-low reset
//  mem_addr   in     32  CPU byte address
//  mem_data   inout  32  CPU data; write data in low bits; driven by this block only while mem_ok && mem_read
//  mem_width  in     2   0 byte, 1 halfword, 2 word, 3 treated as word
//  mem_read   in     1   CPU read request level
//  mem_write  in     1   CPU write request level (read wins if both high)
//  mem_ok     out    1   completion strobe, one cycle
//  dev_req    out    1   device request, held until dev_ack
//  dev_region out    4   0..7 = mem_addr[27:24]; 8 = ROM (0x8..0xD)
//  dev_addr   out    24  {mem_addr[23:2],2'b00}; devices mirror internally
//  dev_we     out    1   1 write, 0 read
//  dev_be     out    4   byte enables
//  dev_wdata  out    32  lane-replicated write data
//  dev_rdata  in     32  aligned word, valid with dev_ack
//  dev_ack    in     1   device completion, sampled at posedge while dev_req=1
//  bus_err    out    1   sticky: dev_ack timeout occurred
// BEHAVIOUR
//  Reset (rstn=0 at posedge): state IDLE; mem_ok=0, dev_req=0, dev_we=0, dev_be=0, bus_err=0, mem_data=z, all counters 0.
//   Mid-operation reset drops dev_req next cycle; devices tolerate abandoned requests.
//  State machine IDLE -> DEV -> WAIT -> DONE -> IDLE:
//   IDLE: on (mem_read|mem_write), latch addr/width/dir/wdata. Mapped and legal -> DEV, dev_req=1 next cycle.
//     Unmapped (addr[31:28]!=0, region 0x1 or 0xE/0xF) or write to BIOS/ROM -> DONE directly, no dev_req.
//   DEV: hold dev_* stable. On dev_ack: capture dev_rdata, drop dev_req. Load wait counter with region WS:
//     WS>0 -> WAIT; WS=0 -> DONE.
//     If TIMEOUT cycles elapse without ack: drop dev_req, set bus_err, read data=0, -> DONE.
//   WAIT: decrement each cycle; at 1 -> DONE.
//   DONE: mem_ok = request still present, same dir, and mem_addr == latched addr (combinational on current inputs).
//     Otherwise mem_ok=0; a write already acked stays committed. Always -> IDLE.
//  Latency: zero-WS region with dev_ack in the first DEV cycle -> mem_ok 2 cycles after request (IDLE, DEV, DONE).
//   Unmapped -> 1 cycle. Region WS adds WS cycles.
//  A request held high after mem_ok is accepted again in IDLE.
//   Repeated identical stores are idempotent, so this is accepted behaviour.
//  Writes: byte -> be=1<<a[1:0], wdata={4{d[7:0]}}; half -> be=a[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}.
//   Word -> be=4'hF, wdata=d (address forced aligned).
//  Reads (zero-extended; CPU sign-extends):
//   byte -> rdata>>(8*a[1:0]) & 0xFF.
//   half -> (rdata>>(16*a[1])) & 0xFFFF, then if a[0]: ror 8.
//   word -> rdata ror (8*a[1:0]).
//   Unmapped/timeout -> 0.
//  mem_data drives only in DONE with mem_read and mem_ok; z at all other times, including during writes.
//  bus_err clears only on reset.
// TESTING
//  1 Word read 0x03000010, dev_ack in first DEV cycle, rdata=0xDEADBEEF -> mem_ok at cycle 2, mem_data=0xDEADBEEF.
//  2 Byte write 0x02000003, data 0xAB -> dev_be=4'b1000, dev_wdata=0xABABABAB, dev_addr=0x000000.
//    WS_EWRAM=2 -> mem_ok at cycle 4.
//  3 Unaligned word read 0x08000001, rdata=0x11223344 -> mem_data=0x44112233, mem_ok after dev_ack+4.
//    Halfword 0x08000002 -> 0x00001122.
//  4 Write 0x00000100 (BIOS), then read 0x10000000 -> no dev_req either, each mem_ok after 1 cycle, read returns 0.
//  5 Read with dev_ack withheld 255 cycles -> dev_req drops, bus_err=1, mem_ok with mem_data=0.
//    Next read completes normally, bus_err stays 1.
//  6 Reset asserted during WAIT, or mem_read dropped in WAIT -> IDLE / no mem_ok. mem_data stays z, dev_req=0.

Source files
------------

// File: rtl/gba_mem_ctrl.sv
`default_nettype none
// gba_mem_ctrl: GBA address decode, per-region wait states and byte/halfword lane alignment
// between the CPU memory port and the req/ack region device bus.  Rev 1.0
module gba_mem_ctrl #(
  parameter int WS_BIOS  = 0,
  parameter int WS_EWRAM = 2,
  parameter int WS_IWRAM = 0,
  parameter int WS_ROM   = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_mem_addr,
  inout  wire  [31:0] io_mem_data,
  input  logic [1:0]  i_mem_width,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  output logic        o_mem_ok,
  output logic        o_dev_req,
  output logic [3:0]  o_dev_region,
  output logic [23:0] o_dev_addr,
  output logic        o_dev_we,
  output logic [3:0]  o_dev_be,
  output logic [31:0] o_dev_wdata,
  input  logic [31:0] i_dev_rdata,
  input  logic        i_dev_ack,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEV  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [1:0]  r_width;
  logic        r_we;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;

  logic        w_req;
  logic        w_we;
  logic        w_mapped;
  logic        w_legal;
  logic [3:0]  w_region;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_dev_ws;
  logic [15:0] w_half;
  logic [31:0] w_rd;

  assign w_req = i_mem_read | i_mem_write;
  assign w_we  = ~i_mem_read & i_mem_write;

  always_comb begin
    w_mapped = 1'b0;
    w_region = 4'd0;
    if (i_mem_addr[31:28] == 4'h0) begin
      case (i_mem_addr[27:24])
        4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
          w_mapped = 1'b1;
          w_region = i_mem_addr[27:24];
        end
        4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
          w_mapped = 1'b1;
          w_region = 4'd8;
        end
        default: ;
      endcase
    end
  end

  // BIOS and ROM are read-only: stores there complete without touching the device bus
  assign w_legal = w_mapped & ~(w_we & ((w_region == 4'd0) | (w_region == 4'd8)));

  always_comb begin
    case (o_dev_region)
      4'd0:    w_dev_ws = 8'(WS_BIOS);
      4'd2:    w_dev_ws = 8'(WS_EWRAM);
      4'd8:    w_dev_ws = 8'(WS_ROM);
      default: w_dev_ws = 8'(WS_IWRAM);
    endcase
  end

  always_comb begin
    case (i_mem_width)
      2'd0: begin
        w_be    = 4'b0001 << i_mem_addr[1:0];
        w_wdata = {4{io_mem_data[7:0]}};
      end
      2'd1: begin
        w_be    = i_mem_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{io_mem_data[15:0]}};
      end
      default: begin
        w_be    = 4'hF;
        w_wdata = io_mem_data;
      end
    endcase
  end

  // Read lanes: zero-extended byte/half, misaligned half and word rotate like the ARM7 core expects
  always_comb begin
    w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
    w_rd   = 32'h0;
    case (r_width)
      2'd0: begin
        case (r_addr[1:0])
          2'd0:    w_rd = {24'h0, r_rdata[7:0]};
          2'd1:    w_rd = {24'h0, r_rdata[15:8]};
          2'd2:    w_rd = {24'h0, r_rdata[23:16]};
          default: w_rd = {24'h0, r_rdata[31:24]};
        endcase
      end
      2'd1:    w_rd = r_addr[0] ? {w_half[7:0], 16'h0, w_half[15:8]} : {16'h0, w_half};
      default: begin
        case (r_addr[1:0])
          2'd0:    w_rd = r_rdata;
          2'd1:    w_rd = {r_rdata[7:0], r_rdata[31:8]};
          2'd2:    w_rd = {r_rdata[15:0], r_rdata[31:16]};
          default: w_rd = {r_rdata[23:0], r_rdata[31:24]};
        endcase
      end
    endcase
  end

  assign o_mem_ok    = (r_state == S_DONE) && w_req && (w_we == r_we) && (i_mem_addr == r_addr);
  assign io_mem_data = (o_mem_ok && !r_we) ? w_rd : 32'bz;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'h0;
      r_width      <= 2'd0;
      r_we         <= 1'b0;
      r_rdata      <= 32'h0;
      r_cnt        <= 8'd0;
      o_dev_req    <= 1'b0;
      o_dev_region <= 4'd0;
      o_dev_addr   <= 24'h0;
      o_dev_we     <= 1'b0;
      o_dev_be     <= 4'h0;
      o_dev_wdata  <= 32'h0;
      o_bus_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr       <= i_mem_addr;
            r_width      <= i_mem_width;
            r_we         <= w_we;
            r_rdata      <= 32'h0;
            r_cnt        <= 8'd0;
            o_dev_region <= w_region;
            o_dev_addr   <= {i_mem_addr[23:2], 2'b00};
            o_dev_we     <= w_we;
            o_dev_be     <= w_we ? w_be : 4'hF;
            o_dev_wdata  <= w_wdata;
            if (w_legal) begin
              o_dev_req <= 1'b1;
              r_state   <= S_DEV;
            end else begin
              r_state   <= S_DONE;
            end
          end
        end
        S_DEV: begin
          if (i_dev_ack) begin
            r_rdata   <= i_dev_rdata;
            o_dev_req <= 1'b0;
            r_cnt     <= w_dev_ws;
            r_state   <= (w_dev_ws == 8'd0) ? S_DONE : S_WAIT;
          end else if (r_cnt == c_to_last) begin
            o_dev_req <= 1'b0;
            o_bus_err <= 1'b1;
            r_rdata   <= 32'h0;
            r_cnt     <= 8'd0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (r_cnt <= 8'd1) begin
            r_cnt   <= 8'd0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gba_mem_ctrl.sv
`default_nettype none
// tb_gba_mem_ctrl: directed and randomized transactions against an address-map/lane reference model.
module tb_gba_mem_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;
  logic [1:0]  mem_width;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ok;
  logic        dev_req;
  logic [3:0]  dev_region;
  logic [23:0] dev_addr;
  logic        dev_we;
  logic [3:0]  dev_be;
  logic [31:0] dev_wdata;
  logic [31:0] dev_rdata;
  logic        dev_ack;
  logic        bus_err;

  logic        drv_en;
  logic [31:0] drv_val;
  assign mem_data = drv_en ? drv_val : 32'bz;

  int n_cmp = 0;
  int n_bad = 0;
  bit m_buserr = 1'b0;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic [23:0] obs_addr;

  gba_mem_ctrl dut (
    .clk(clk), .rstn(rstn),
    .i_mem_addr(mem_addr), .io_mem_data(mem_data), .i_mem_width(mem_width),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .o_mem_ok(mem_ok),
    .o_dev_req(dev_req), .o_dev_region(dev_region), .o_dev_addr(dev_addr),
    .o_dev_we(dev_we), .o_dev_be(dev_be), .o_dev_wdata(dev_wdata),
    .i_dev_rdata(dev_rdata), .i_dev_ack(dev_ack), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Undriven bus reads as z in four-state simulators and as 0 in two-state ones
  function automatic bit floating(input logic [31:0] v);
    return (v === 32'bz) || (v === 32'h0);
  endfunction

  function automatic int m_region(input logic [31:0] a);
    int n;
    if (a[31:28] != 4'h0) return -1;
    n = int'(a[27:24]);
    if (n == 1 || n >= 14) return -1;
    return (n >= 8) ? 8 : n;
  endfunction

  function automatic int m_ws(input int r);
    case (r)
      0: return 0;
      2: return 2;
      8: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int m_size(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] w);
    int sz = m_size(w);
    int off = ((int'(a) % 4) / sz) * sz;
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] w);
    logic [31:0] r;
    int sz = m_size(w);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] w, input logic [31:0] r);
    logic [31:0] h;
    int lo = int'(a[1:0]);
    if (w == 2'd0) return (r >> (8 * lo)) & 32'hFF;
    if (w == 2'd1) begin
      h = (r >> (16 * (lo / 2))) & 32'hFFFF;
      return (lo % 2 == 1) ? ror32(h, 8) : h;
    end
    return ror32(r, 8 * lo);
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [1:0] w, input bit rd,
                         input logic [31:0] d, input int dly, input bit withhold,
                         input logic [31:0] rdat, output logic [31:0] got, output int lat);
    int  reg_e = m_region(a);
    bit  legal = (reg_e >= 0) && !(!rd && (reg_e == 0 || reg_e == 8));
    int  exp_lat;
    logic [31:0] exp_rd;
    bit  seen = 1'b0;
    int  dcyc = 0;
    if (!legal) exp_lat = 1;
    else if (withhold) exp_lat = 256;
    else exp_lat = 2 + dly + m_ws(reg_e);
    exp_rd = (!legal || withhold) ? 32'h0 : m_read(a, w, rdat);
    if (legal && withhold) m_buserr = 1'b1;
    got = 32'h0;
    lat = -1;
    @(negedge clk);
    mem_addr = a; mem_width = w; mem_read = rd; mem_write = !rd;
    drv_en = !rd; drv_val = d;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      dev_ack = 1'b0;
      if (dev_req) begin
        if (!seen) begin
          seen = 1'b1;
          obs_be = dev_be; obs_wdata = dev_wdata; obs_addr = dev_addr;
          chk("dev_region", 32'(dev_region), 32'(reg_e));
          chk("dev_addr", 32'(dev_addr), a & 32'h00FF_FFFC);
          chk("dev_we", 32'(dev_we), 32'(!rd));
          if (!rd) begin
            chk("dev_be", 32'(dev_be), 32'(m_be(a, w)));
            chk("dev_wdata", dev_wdata, m_wdata(d, w));
          end
        end
        dcyc++;
        if (!withhold && dcyc == dly + 1) begin
          dev_ack = 1'b1;
          dev_rdata = rdat;
        end
      end
      if (mem_ok) begin
        lat = k;
        got = mem_data;
        break;
      end
      if (rd && k == 1) chk("early_drive", 32'(floating(mem_data)), 32'd1);
    end
    mem_read = 1'b0; mem_write = 1'b0; drv_en = 1'b0; dev_ack = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("dev_req_seen", 32'(seen), 32'(legal));
    if (rd) chk("rdata", got, exp_rd);
    if (legal && withhold) chk("timeout_cycles", 32'(dcyc), 32'd255);
    @(negedge clk);
    chk("ok_strobe", 32'(mem_ok), 32'd0);
    if (rd) chk("release", 32'(floating(mem_data)), 32'd1);
    chk("bus_err", 32'(bus_err), 32'(m_buserr));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int lat;
    bit saw_ok, bad_z;
    int nibs[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 13, 14, 15};

    rstn = 1'b0; mem_addr = 32'h0; mem_width = 2'd0; mem_read = 1'b0; mem_write = 1'b0;
    drv_en = 1'b0; drv_val = 32'h0; dev_rdata = 32'h0; dev_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dev_req", 32'(dev_req), 32'd0);
    chk("rst_mem_ok", 32'(mem_ok), 32'd0);
    chk("rst_dev_we", 32'(dev_we), 32'd0);
    chk("rst_dev_be", 32'(dev_be), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_mem_data", 32'(floating(mem_data)), 32'd1);
    rstn = 1'b1;

    run_txn(32'h0300_0010, 2'd2, 1'b1, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, got, lat);
    chk("t1_data", got, 32'hDEAD_BEEF);
    chk("t1_lat", 32'(lat), 32'd2);
    run_txn(32'h0200_0003, 2'd0, 1'b0, 32'h0000_00AB, 0, 1'b0, 32'h0, got, lat);
    chk("t2_be", 32'(obs_be), 32'h8);
    chk("t2_wdata", obs_wdata, 32'hABAB_ABAB);
    chk("t2_addr", 32'(obs_addr), 32'h0);
    chk("t2_lat", 32'(lat), 32'd4);
    run_txn(32'h0800_0001, 2'd2, 1'b1, 32'h0, 0, 1'b0, 32'h1122_3344, got, lat);
    chk("t3_word", got, 32'h4411_2233);
    chk("t3_lat", 32'(lat), 32'd6);
    run_txn(32'h0800_0002, 2'd1, 1'b1, 32'h0, 2, 1'b0, 32'h1122_3344, got, lat);
    chk("t3_half", got, 32'h0000_1122);
    run_txn(32'h0000_0100, 2'd2, 1'b0, 32'h1234_5678, 0, 1'b0, 32'h0, got, lat);
    chk("t4_bios_wr_lat", 32'(lat), 32'd1);
    run_txn(32'h1000_0000, 2'd2, 1'b1, 32'h0, 0, 1'b0, 32'hFFFF_FFFF, got, lat);
    chk("t4_unmapped_data", got, 32'h0);
    run_txn(32'h0300_0000, 2'd2, 1'b1, 32'h0, 0, 1'b1, 32'h5555_AAAA, got, lat);
    chk("t5_data", got, 32'h0);
    chk("t5_bus_err", 32'(bus_err), 32'd1);
    run_txn(32'h0300_0004, 2'd2, 1'b1, 32'h0, 1, 1'b0, 32'hCAFE_F00D, got, lat);
    chk("t5_after", got, 32'hCAFE_F00D);

    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      a = {4'h0, 4'(nibs[$urandom_range(0, 12)]), 24'($urandom)};
      if ($urandom_range(0, 7) == 0) a[31:28] = 4'($urandom_range(1, 15));
      run_txn(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 3), 1'b0, $urandom, got, lat);
    end

    // Request withdrawn during the EWRAM wait phase: no completion, bus stays released
    saw_ok = 1'b0; bad_z = 1'b0;
    @(negedge clk);
    mem_addr = 32'h0200_0004; mem_width = 2'd2; mem_read = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      dev_ack = 1'b0;
      if (mem_ok) saw_ok = 1'b1;
      if (!floating(mem_data)) bad_z = 1'b1;
      if (k == 1) begin dev_ack = 1'b1; dev_rdata = 32'h1357_9BDF; end
      if (k == 2) mem_read = 1'b0;
    end
    chk("drop_ok", 32'(saw_ok), 32'd0);
    chk("drop_drive", 32'(bad_z), 32'd0);
    chk("drop_dev_req", 32'(dev_req), 32'd0);

    // Reset during the ROM wait phase
    saw_ok = 1'b0; bad_z = 1'b0;
    @(negedge clk);
    mem_addr = 32'h0800_0000; mem_width = 2'd2; mem_read = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      dev_ack = 1'b0;
      if (mem_ok) saw_ok = 1'b1;
      if (!floating(mem_data)) bad_z = 1'b1;
      if (k == 1) begin dev_ack = 1'b1; dev_rdata = 32'h2468_ACE0; end
      if (k == 3) begin rstn = 1'b0; mem_read = 1'b0; end
      if (k == 4) begin
        rstn = 1'b1;
        chk("rst_mid_dev_req", 32'(dev_req), 32'd0);
      end
    end
    chk("rst_mid_ok", 32'(saw_ok), 32'd0);
    chk("rst_mid_drive", 32'(bad_z), 32'd0);
    chk("rst_mid_bus_err", 32'(bus_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
